// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: default widths, NOP encoding, opcodes and
// the fetch-stage FSM state type.
package mips_pkg;

    localparam int unsigned MIPS_PC_W   = 10;
    localparam int unsigned MIPS_INST_W = 32;
    localparam logic [31:0] MIPS_NOP    = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, addresses the 1-cycle
// synchronous instruction ROM and drives the IF/ID register.
// Optional macro IF_HALT_EN: OP_HALT captured into IF/ID stops fetch until
// a redirect or reset.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned     PC_W     = MIPS_PC_W,
    parameter int unsigned     INST_W   = MIPS_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [INST_W-1:0] imem_q_i,
    output logic [INST_W-1:0] if_inst_o,
    output logic [PC_W-1:0]   if_pc_o,
    output logic [PC_W-1:0]   if_pc_plus1_o,
    output logic              if_valid_o,
    output logic              halted_o
);

    fetch_state_e      r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_req_pc;
    logic              r_req_vld;
    logic [INST_W-1:0] r_if_inst;
    logic [PC_W-1:0]   r_if_pc;
    logic              r_if_valid;
    logic [PC_W-1:0]   w_imem_addr;

`ifdef IF_HALT_EN
    logic r_halted;
    logic w_is_halt;

    // Halt opcode detect on the word arriving from the ROM
    assign w_is_halt = (imem_q_i[INST_W-1 -: 6] == OP_HALT);
    assign halted_o  = r_halted;
`else
    assign halted_o  = 1'b0;
`endif

    // Next ROM address; re-reading req_pc keeps imem_q_i stable while not advancing
    always_comb begin
        w_imem_addr = r_pc;
        if (!rst) begin
            w_imem_addr = RESET_PC;
        end else if (redirect_i) begin
            w_imem_addr = redirect_pc_i;
        end else if (stall_i || (r_state != ST_RUN)) begin
            w_imem_addr = r_req_pc;
        end
    end

    // Fetch FSM, PC tracking and IF/ID register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_FILL;
            r_pc       <= RESET_PC + PC_W'(1);
            r_req_pc   <= RESET_PC;
            r_req_vld  <= 1'b0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
`ifdef IF_HALT_EN
            r_halted   <= 1'b0;
`endif
        end else if (redirect_i) begin
            // Squash the wrong-path word; target lands in IF/ID next edge
            r_state    <= ST_RUN;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            r_req_pc   <= redirect_pc_i;
            r_req_vld  <= 1'b1;
            r_pc       <= redirect_pc_i + PC_W'(1);
`ifdef IF_HALT_EN
            r_halted   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (!stall_i) begin
                        r_req_vld <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        r_if_inst  <= imem_q_i;
                        r_if_pc    <= r_req_pc;
                        r_if_valid <= r_req_vld;
                        r_req_pc   <= r_pc;
                        r_req_vld  <= 1'b1;
                        r_pc       <= r_pc + PC_W'(1);
`ifdef IF_HALT_EN
                        if (r_req_vld && w_is_halt) begin
                            r_state <= ST_HALTED;
                        end
`endif
                    end
                end
`ifdef IF_HALT_EN
                ST_HALTED: begin
                    r_if_inst  <= NOP_INST;
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
`endif
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign imem_addr_o   = w_imem_addr;
    assign if_inst_o     = r_if_inst;
    assign if_pc_o       = r_if_pc;
    assign if_valid_o    = r_if_valid;
    assign if_pc_plus1_o = r_if_pc + PC_W'(1);

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Testbench for mips_fetch_stage: ROM model, table-driven cycle vectors with
// a scoreboard queue, plus hand-written halt-opcode sequences.
module tb_mips_fetch_stage;

    localparam int unsigned PW = 10;
    localparam int unsigned IW = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic          rst;
        logic          stall;
        logic          redir;
        logic [PW-1:0] rpc;
        logic          chk_addr;
        logic [PW-1:0] exp_addr;
        logic          exp_v;
        logic          chk_pc;
        logic [PW-1:0] exp_pc;
        logic          chk_inst;
        logic [IW-1:0] exp_inst;
        logic          exp_halt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [PW-1:0] redirect_pc_i = '0;
    logic [PW-1:0] imem_addr_o;
    logic [IW-1:0] imem_q_i;
    logic [IW-1:0] if_inst_o;
    logic [PW-1:0] if_pc_o;
    logic [PW-1:0] if_pc_plus1_o;
    logic          if_valid_o;
    logic          halted_o;

    logic [IW-1:0] mem [0:1023];
    vec_t          tbl [$];
    vec_t          sb  [$];
    int            n_checks = 0;
    int            n_err = 0;

    mips_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_q_i      (imem_q_i),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o),
        .if_pc_plus1_o (if_pc_plus1_o),
        .if_valid_o    (if_valid_o),
        .halted_o      (halted_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency
    always @(posedge clk) imem_q_i <= mem[imem_addr_o];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic r, input logic s, input logic d,
                                 input int rpc, input logic v, input int pc);
        vec_t t;
        t.rst      = r;
        t.stall    = s;
        t.redir    = d;
        t.rpc      = PW'(rpc);
        t.chk_addr = 1'b0;
        t.exp_addr = '0;
        t.exp_v    = v;
        t.chk_pc   = v | ~r;
        t.exp_pc   = PW'(pc);
        t.chk_inst = v | ~r | d;
        t.exp_inst = v ? (32'h2000_0000 | 32'(pc)) : NOP;
        t.exp_halt = 1'b0;
        return t;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic run_row(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst           = v.rst;
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        sb.push_back(v);
        #1;
        if (v.chk_addr) check("imem_addr", 32'(imem_addr_o), 32'(v.exp_addr));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("if_valid", 32'(if_valid_o), 32'(e.exp_v));
            check("halted", 32'(halted_o), 32'(e.exp_halt));
            if (e.chk_pc) begin
                check("if_pc", 32'(if_pc_o), 32'(e.exp_pc));
                check("if_pc_plus1", 32'(if_pc_plus1_o), 32'(PW'(e.exp_pc + PW'(1))));
            end
            if (e.chk_inst) check("if_inst", if_inst_o, e.exp_inst);
        end
    endtask

    initial begin
        vec_t t;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);

        // reset held 3 cycles, then fill bubble, then sequential fetch 0..5
        for (int i = 0; i < 3; i++) tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 0, 1'b0, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b0, 0));
        for (int p = 0; p <= 5; p++) tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, p));
        // stall 3 cycles at pc 5: hold IF/ID, ROM address pinned at 6
        for (int i = 0; i < 3; i++) begin
            t = mkv(1'b1, 1'b1, 1'b0, 0, 1'b1, 5);
            t.chk_addr = 1'b1;
            t.exp_addr = PW'(6);
            tbl.push_back(t);
        end
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 6));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 7));
        // redirect to 100 with stall also high: redirect wins
        t = mkv(1'b1, 1'b1, 1'b1, 100, 1'b0, 0);
        t.chk_addr = 1'b1;
        t.exp_addr = PW'(100);
        tbl.push_back(t);
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 100));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 101));
        // wrap at top of address space
        tbl.push_back(mkv(1'b1, 1'b0, 1'b1, 1022, 1'b0, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 1022));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 1023));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 0));
        // reach pc 40, then one-edge reset mid-run
        tbl.push_back(mkv(1'b1, 1'b0, 1'b1, 38, 1'b0, 0));
        for (int p = 38; p <= 40; p++) tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, p));
        tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 500, 1'b0, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b0, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 1));
        // back-to-back redirects, second one while IF/ID holds a bubble
        tbl.push_back(mkv(1'b1, 1'b0, 1'b1, 200, 1'b0, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b1, 300, 1'b0, 0));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 300));
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 301));

        foreach (tbl[i]) run_row(tbl[i]);

        // Halt opcode at word 3
        mem[3] = 32'hFC00_0000;
        run_row(mkv(1'b0, 1'b0, 1'b0, 0, 1'b0, 0));
        run_row(mkv(1'b1, 1'b0, 1'b0, 0, 1'b0, 0));
        for (int p = 0; p <= 2; p++) run_row(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, p));
        t = mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 3);
        t.exp_inst = 32'hFC00_0000;
        run_row(t);
`ifdef IF_HALT_EN
        for (int i = 0; i < 10; i++) begin
            t = mkv(1'b1, 1'(i % 2), 1'b0, 0, 1'b0, 0);
            t.chk_inst = 1'b1;
            t.exp_halt = 1'b1;
            run_row(t);
        end
        run_row(mkv(1'b1, 1'b1, 1'b1, 10, 1'b0, 0));
        run_row(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 10));
        run_row(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, 11));
`else
        for (int p = 4; p <= 6; p++) run_row(mkv(1'b1, 1'b0, 1'b0, 0, 1'b1, p));
`endif

        if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
